// File: rtl/mostra_sequencia.sv
// Sequence presenter: walks the game memory from entry 0 to the latched round and lights each entry on the LEDs.
// Optional dark gap between entries is built when MOSTRA_SEQUENCIA_GAP_EN is defined.
module mostra_sequencia #(
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] rodada,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    FIM     = 4'd4
  } estado_t;

  estado_t       estado, estado_n;
  logic [3:0]    endereco, endereco_n;
  logic [3:0]    limite, limite_n;
  logic [3:0]    dado_reg, dado_n;
  logic [TW-1:0] timer, timer_n;
  logic          ultimo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      endereco <= 4'd0;
      limite   <= 4'd0;
      dado_reg <= 4'd0;
      timer    <= '0;
    end else begin
      estado   <= estado_n;
      endereco <= endereco_n;
      limite   <= limite_n;
      dado_reg <= dado_n;
      timer    <= timer_n;
    end
  end

  assign ultimo = (endereco == limite);

  always_comb begin
    estado_n   = estado;
    endereco_n = endereco;
    limite_n   = limite;
    dado_n     = dado_reg;
    timer_n    = timer;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          limite_n   = rodada;
          endereco_n = 4'd0;
          estado_n   = CARREGA;
        end
      end
      CARREGA: begin
        dado_n   = mem_dado;
        timer_n  = '0;
        estado_n = ACESO;
      end
      ACESO: begin
        timer_n = timer + TW'(1);
        if (timer == TW'(ON_CYCLES - 1)) begin
          timer_n = '0;
`ifdef MOSTRA_SEQUENCIA_GAP_EN
          estado_n = APAGADO;
`else
          // Without a gap, the CARREGA cycle is the only dark slot between entries.
          if (ultimo) estado_n = FIM;
          else begin
            endereco_n = endereco + 4'd1;
            estado_n   = CARREGA;
          end
`endif
        end
      end
      APAGADO: begin
`ifdef MOSTRA_SEQUENCIA_GAP_EN
        timer_n = timer + TW'(1);
        if (timer == TW'(OFF_CYCLES - 1)) begin
          timer_n = '0;
          if (ultimo) estado_n = FIM;
          else begin
            endereco_n = endereco + 4'd1;
            estado_n   = CARREGA;
          end
        end
`else
        estado_n = OCIOSO;
`endif
      end
      FIM:     estado_n = OCIOSO;
      default: estado_n = OCIOSO;
    endcase
    // Abort overrides any transition, including a start in OCIOSO.
    if (abortar) begin
      estado_n   = OCIOSO;
      endereco_n = 4'd0;
    end
  end

  assign leds         = (estado == ACESO) ? dado_reg : 4'd0;
  assign mem_endereco = endereco;
  assign ocupado      = (estado != OCIOSO);
  assign pronto       = (estado == FIM);
  assign db_estado    = estado;

endmodule
